// File: rtl/cdb_broadcaster_if.sv
// Result-bus bundle for the CDB broadcaster.
// The FU result inputs and the CDB broadcast outputs share this one interface.
interface cdb_broadcaster_if #(
  parameter int NUM_FU = 4,
  parameter int TAG_W  = 5,
  parameter int XLEN   = 32
);
  logic [NUM_FU-1:0]       fu_valid;
  logic [NUM_FU*TAG_W-1:0] fu_tag;
  logic [NUM_FU*XLEN-1:0]  fu_value;
  logic [NUM_FU-1:0]       fu_ready;
  logic                    cdb_valid;
  logic [TAG_W-1:0]        cdb_tag;
  logic [XLEN-1:0]         cdb_value;

  // master = functional units plus CDB consumers, slave = the broadcaster
  modport master (
    output fu_valid, fu_tag, fu_value,
    input  fu_ready, cdb_valid, cdb_tag, cdb_value
  );

  modport slave (
    input  fu_valid, fu_tag, fu_value,
    output fu_ready, cdb_valid, cdb_tag, cdb_value
  );
endinterface

// File: rtl/cdb_broadcaster.sv
// Common Data Bus transmit end: per-FU result FIFOs, a round-robin arbiter and a
// registered one-result-per-cycle broadcast. Tag 0 is reserved to mean "no broadcast".
module cdb_broadcaster #(
  parameter int NUM_FU    = 4,
  parameter int BUF_DEPTH = 2,
  parameter int TAG_W     = 5,
  parameter int XLEN      = 32
) (
  input  logic clock,
  input  logic reset,
  input  logic squash,
  cdb_broadcaster_if.slave bus
);
  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int RR_W  = $clog2(NUM_FU);

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  value;
  } result_t;

  result_t          mem    [NUM_FU][BUF_DEPTH];
  logic [CNT_W-1:0] count  [NUM_FU];
  logic [PTR_W-1:0] wr_ptr [NUM_FU];
  logic [PTR_W-1:0] rd_ptr [NUM_FU];

  logic [RR_W-1:0]   rr_ptr;
  logic [NUM_FU-1:0] ready;
  logic [NUM_FU-1:0] push;
  logic [NUM_FU-1:0] pop;
  logic              grant_valid;
  logic [RR_W-1:0]   grant;
  logic [RR_W:0]     scan_sum;
  logic [RR_W-1:0]   scan_idx;
  result_t           head;

  logic              cdb_valid_q;
  logic [TAG_W-1:0]  cdb_tag_q;
  logic [XLEN-1:0]   cdb_value_q;

  // Ready comes only from registered occupancy, so a full FIFO stays closed even
  // while its head is being broadcast. A tag-0 result handshakes but is dropped.
  always_comb begin
    ready = '0;
    push  = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      ready[i] = (count[i] != CNT_W'(BUF_DEPTH)) && !squash && !reset;
      push[i]  = bus.fu_valid[i] && ready[i] && (bus.fu_tag[i*TAG_W +: TAG_W] != '0);
    end
  end

  assign bus.fu_ready = ready;

  // NOTE: scan_sum/scan_idx are reused each iteration, which is only correct with
  // blocking assignments; every output of this block is defaulted first so no latch forms.
  always_comb begin
    grant_valid = 1'b0;
    grant       = '0;
    scan_sum    = '0;
    scan_idx    = '0;
    pop         = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      scan_sum = {1'b0, rr_ptr} + (RR_W+1)'(k);
      if (scan_sum >= (RR_W+1)'(NUM_FU))
        scan_sum = scan_sum - (RR_W+1)'(NUM_FU);
      scan_idx = scan_sum[RR_W-1:0];
      if (!grant_valid && (count[scan_idx] != '0)) begin
        grant_valid = 1'b1;
        grant       = scan_idx;
      end
    end
    if (grant_valid && !squash)
      pop[grant] = 1'b1;
  end

  assign head = mem[grant][rd_ptr[grant]];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_FU; i++) begin
        count[i]  <= '0;
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
    end else if (squash) begin
      for (int i = 0; i < NUM_FU; i++) begin
        count[i]  <= '0;
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
        case ({push[i], pop[i]})
          2'b10:   count[i] <= count[i] + 1'b1;
          2'b01:   count[i] <= count[i] - 1'b1;
          default: count[i] <= count[i];
        endcase
      end
    end
  end

  // NOTE: FIFO storage has no reset; validity is carried entirely by count/pointers,
  // and leaving the array unreset lets it map onto plain flops or RAM without a clear path.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (push[i])
        mem[i][wr_ptr[i]] <= '{tag: bus.fu_tag[i*TAG_W +: TAG_W],
                               value: bus.fu_value[i*XLEN +: XLEN]};
    end
  end

  // Broadcast register: exactly one cycle per winner, zeros when idle or squashed.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr      <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_value_q <= '0;
    end else if (squash || !grant_valid) begin
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_value_q <= '0;
    end else begin
      cdb_valid_q <= 1'b1;
      cdb_tag_q   <= head.tag;
      cdb_value_q <= head.value;
      rr_ptr      <= (grant == RR_W'(NUM_FU-1)) ? '0 : grant + 1'b1;
    end
  end

  assign bus.cdb_valid = cdb_valid_q;
  assign bus.cdb_tag   = cdb_tag_q;
  assign bus.cdb_value = cdb_value_q;
endmodule
